weight_pingpong_buffer: RTL

- Double-buffered (ping-pong) weight store for the LSTM gate datapath.
- One bank (the load bank) is filled word-serially through a valid/ready stream while the other (the active bank) feeds compute.
- Compute reads either as a full-width parallel snapshot of all DEPTH words or as single words by address.
- A swap handshake exchanges the banks, so the next timestep's weights load without stalling compute.

---
 rtl/weight_pingpong_buffer.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/weight_pingpong_buffer.sv
// Double-buffered LSTM weight store. One bank is filled word-serially through a
// valid/ready stream while the other bank feeds compute, either as a full
// parallel snapshot or as single addressed words. A swap exchanges the roles.
module weight_pingpong_buffer #(
  parameter int RAM_WIDTH = 16,
  parameter int RAM_DEPTH = 400,
  parameter int RAM_ADDR  = 9
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [RAM_WIDTH-1:0]           in_data,
  input  logic                           load_restart,
  input  logic                           swap_req,
  output logic                           swap_ack,
  output logic                           load_full,
  input  logic                           rd_all_en,
  output logic [RAM_WIDTH*RAM_DEPTH-1:0] wout_all,
  output logic                           wout_valid,
  input  logic                           rd_en,
  input  logic [RAM_ADDR-1:0]            rd_addr,
  output logic [RAM_WIDTH-1:0]           rd_data,
  output logic                           rd_valid
);

  // Index width just wide enough to address RAM_DEPTH words.
  localparam int IDX_W = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RAM_DEPTH - 1);

  typedef enum logic {
    S_LOAD = 1'b0,
    S_FULL = 1'b1
  } state_t;

  // Bank storage; contents survive rst and are only overwritten by loading.
  logic [RAM_WIDTH-1:0] r_bank0 [RAM_DEPTH];
  logic [RAM_WIDTH-1:0] r_bank1 [RAM_DEPTH];

  state_t               r_state;
  state_t               w_state_next;
  logic [IDX_W-1:0]     r_wr_ptr;
  logic [IDX_W-1:0]     w_wr_ptr_next;
  logic                 r_active_sel;    // 0: bank0 active, bank1 loading
  logic                 w_active_sel_next;
  logic                 r_swap_ack;
  logic                 w_swap;
  logic                 w_wr_en;
  logic                 w_in_ready;

  logic [RAM_WIDTH-1:0] r_rd_data;
  logic                 r_rd_valid;
  logic                 r_wout_valid;
  logic [RAM_WIDTH-1:0] r_wout_word [RAM_DEPTH];

  logic [IDX_W-1:0]     w_rd_idx;
  logic                 w_rd_in_range;
  logic [RAM_WIDTH-1:0] w_rd_word;

  // Load/swap control: next state, pointer, bank select and write enable.
  always_comb begin
    w_state_next      = r_state;
    w_wr_ptr_next     = r_wr_ptr;
    w_active_sel_next = r_active_sel;
    w_swap            = 1'b0;
    w_wr_en           = 1'b0;
    w_in_ready        = 1'b0;
    case (r_state)
      S_LOAD: begin
        w_in_ready = 1'b1;
        if (in_valid && !load_restart && !rst) begin
          w_wr_en = 1'b1;
          if (r_wr_ptr == LAST_IDX) begin
            w_wr_ptr_next = '0;
            w_state_next  = S_FULL;
          end else begin
            w_wr_ptr_next = r_wr_ptr + IDX_W'(1);
          end
        end
      end
      S_FULL: begin
        // Swap requests are only honoured once the load bank is complete.
        if (swap_req) begin
          w_swap            = 1'b1;
          w_active_sel_next = ~r_active_sel;
          w_state_next      = S_LOAD;
          w_wr_ptr_next     = '0;
        end
      end
      default: begin
        w_state_next  = S_LOAD;
        w_wr_ptr_next = '0;
      end
    endcase
    // Restart overrides both a pending swap and the write beat in this cycle.
    if (load_restart) begin
      w_state_next      = S_LOAD;
      w_wr_ptr_next     = '0;
      w_active_sel_next = r_active_sel;
      w_swap            = 1'b0;
      w_wr_en           = 1'b0;
    end
  end

  // Control state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_LOAD;
      r_wr_ptr     <= '0;
      r_active_sel <= 1'b0;
      r_swap_ack   <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_wr_ptr     <= w_wr_ptr_next;
      r_active_sel <= w_active_sel_next;
      r_swap_ack   <= w_swap;
    end
  end

  // Load-bank write; the active bank is never written.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      if (r_active_sel) begin
        r_bank0[r_wr_ptr] <= in_data;
      end else begin
        r_bank1[r_wr_ptr] <= in_data;
      end
    end
  end

  assign w_rd_idx      = rd_addr[IDX_W-1:0];
  assign w_rd_in_range = (32'(rd_addr) < 32'(RAM_DEPTH));
  assign w_rd_word     = r_active_sel ? r_bank1[w_rd_idx] : r_bank0[w_rd_idx];

  // Single-word read of the pre-edge active bank; out-of-range returns zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= rd_en;
      if (rd_en) begin
        r_rd_data <= w_rd_in_range ? w_rd_word : '0;
      end
    end
  end

  // Snapshot-valid flag: sticky from the first capture until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wout_valid <= 1'b0;
    end else if (rd_all_en) begin
      r_wout_valid <= 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < RAM_DEPTH; gi++) begin : g_snap
      // Capture word gi of the active bank into the parallel snapshot.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_wout_word[gi] <= '0;
        end else if (rd_all_en) begin
          r_wout_word[gi] <= r_active_sel ? r_bank1[gi] : r_bank0[gi];
        end
      end
      assign wout_all[RAM_WIDTH*gi +: RAM_WIDTH] = r_wout_word[gi];
    end
  endgenerate

  assign in_ready   = w_in_ready & ~rst;
  assign load_full  = (r_state == S_FULL);
  assign swap_ack   = r_swap_ack;
  assign rd_data    = r_rd_data;
  assign rd_valid   = r_rd_valid;
  assign wout_valid = r_wout_valid;

endmodule
